usb_bus_arb: RTL and testbench

Two-requester arbiter for the USB core's 12-bit-address / 16-bit-data control bus (`bus_addr`/`bus_din`/`bus_dout`/`bus_cyc`/`bus_we`/`bus_ack`). It lets a CPU-side master (m0) and a hardware sequencer (m1, e.g. EP/descriptor setup) share the core's register port. It grants the bus round-robin and latches each transaction's fields. A watchdog aborts any transaction the core never acknowledges. It sits directly between the masters and the `usb` core's bus port, in the `clk_48m` domain.

---
 rtl/usb_bus_arb.sv | 115 +++++++++++
 tb/tb_usb_bus_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_bus_arb.sv
// usb_bus_arb: round-robin arbiter letting two masters (m0 = CPU side,
//   m1 = hardware sequencer) share the usb core's register bus, with a
//   per-transaction watchdog that aborts requests the core never acks.
// Latency: grant one cycle after a request is seen in IDLE; ack/err are
//   combinational in the core's ack cycle (or the last watchdog cycle).
// Backpressure: requesters hold mX_cyc until mX_ack/mX_err; the loser of
//   a tie simply waits in IDLE until the bus returns.
//
// Ports:
//   clk_48m, rst              clock, synchronous active-high reset
//   m0_*/m1_*                 requester side: addr/din/we/cyc in, ack/err/dout out
//   s_addr/s_din/s_we/s_cyc   registered request to the core bus port
//   s_dout/s_ack              core read data and completion
//   to_count                  saturating count of watchdog aborts
module usb_bus_arb #(
  parameter int TIMEOUT = 128
) (
  input  logic        clk_48m,
  input  logic        rst,
  input  logic [11:0] m0_addr,
  input  logic [15:0] m0_din,
  input  logic        m0_we,
  input  logic        m0_cyc,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [15:0] m0_dout,
  input  logic [11:0] m1_addr,
  input  logic [15:0] m1_din,
  input  logic        m1_we,
  input  logic        m1_cyc,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [15:0] m1_dout,
  output logic [11:0] s_addr,
  output logic [15:0] s_din,
  output logic        s_we,
  output logic        s_cyc,
  input  logic [15:0] s_dout,
  input  logic        s_ack,
  output logic [7:0]  to_count
);

  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]     state;
  logic           grant;
  logic           last;
  logic [WDW-1:0] wd;
  logic           pick;
  logic           busy;
  logic           done_ack;
  logic           done_to;

  // Requester chosen in IDLE: m1 if it is alone, or if both ask and m0
  // had the bus last. Only meaningful when at least one cyc is high.
  assign pick = m1_cyc & (~m0_cyc | ~last);

  // Gating with rst keeps a transaction interrupted by reset from
  // emitting a stray ack/err in the reset cycle itself.
  assign busy     = (state == ST_BUSY) && !rst;
  assign done_ack = busy && s_ack;
  assign done_to  = busy && !s_ack && (wd == WD_LAST);

  assign s_cyc   = (state == ST_BUSY);
  assign m0_ack  = done_ack & ~grant;
  assign m1_ack  = done_ack &  grant;
  assign m0_err  = done_to  & ~grant;
  assign m1_err  = done_to  &  grant;
  assign m0_dout = m0_ack ? s_dout : 16'h0000;
  assign m1_dout = m1_ack ? s_dout : 16'h0000;

  always_ff @(posedge clk_48m) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= 1'b0;
      last     <= 1'b1;
      wd       <= '0;
      s_addr   <= 12'h000;
      s_din    <= 16'h0000;
      s_we     <= 1'b0;
      to_count <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_cyc || m1_cyc) begin
            s_addr <= pick ? m1_addr : m0_addr;
            s_din  <= pick ? m1_din  : m0_din;
            s_we   <= pick ? m1_we   : m0_we;
            grant  <= pick;
            last   <= pick;
            wd     <= '0;
            state  <= ST_BUSY;
          end
        end
        default: begin
          if (s_ack) begin
            state <= ST_IDLE;
          end else if (wd == WD_LAST) begin
            state <= ST_IDLE;
            if (to_count != 8'hFF) begin
              to_count <= to_count + 8'h01;
            end
          end else begin
            wd <= wd + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_bus_arb.sv
// tb_usb_bus_arb: directed bench for usb_bus_arb (TIMEOUT = 128).
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
module tb_usb_bus_arb;

  logic        clk_48m = 1'b0;
  logic        rst;
  logic [11:0] m0_addr, m1_addr;
  logic [15:0] m0_din, m1_din;
  logic        m0_we, m1_we, m0_cyc, m1_cyc;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [15:0] m0_dout, m1_dout;
  logic [11:0] s_addr;
  logic [15:0] s_din;
  logic        s_we, s_cyc;
  logic [15:0] s_dout;
  logic        s_ack;
  logic [7:0]  to_count;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk_48m = ~clk_48m;

  usb_bus_arb #(.TIMEOUT(128)) dut (
    .clk_48m (clk_48m),
    .rst     (rst),
    .m0_addr (m0_addr),
    .m0_din  (m0_din),
    .m0_we   (m0_we),
    .m0_cyc  (m0_cyc),
    .m0_ack  (m0_ack),
    .m0_err  (m0_err),
    .m0_dout (m0_dout),
    .m1_addr (m1_addr),
    .m1_din  (m1_din),
    .m1_we   (m1_we),
    .m1_cyc  (m1_cyc),
    .m1_ack  (m1_ack),
    .m1_err  (m1_err),
    .m1_dout (m1_dout),
    .s_addr  (s_addr),
    .s_din   (s_din),
    .s_we    (s_we),
    .s_cyc   (s_cyc),
    .s_dout  (s_dout),
    .s_ack   (s_ack),
    .to_count(to_count)
  );

  task automatic tick();
    @(posedge clk_48m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_addr = '0; m0_din = '0; m0_we = 1'b0; m0_cyc = 1'b0;
    m1_addr = '0; m1_din = '0; m1_we = 1'b0; m1_cyc = 1'b0;
    s_dout = '0; s_ack = 1'b0;

    // Reset state
    repeat (3) tick();
    #1;
    check("rst_s_cyc", s_cyc, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_din", s_din, 0);
    check("rst_s_we", s_we, 0);
    check("rst_to_count", to_count, 0);
    check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check("rst_douts", {m0_dout, m1_dout}, 0);

    // Single write from m0, core acks in the 4th BUSY cycle
    rst = 1'b0;
    m0_cyc = 1'b1; m0_addr = 12'h000; m0_din = 16'h8001; m0_we = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(); #1;
      check("wr_s_cyc", s_cyc, 1);
      check("wr_s_addr", s_addr, 12'h000);
      check("wr_s_din", s_din, 16'h8001);
      check("wr_s_we", s_we, 1);
      check("wr_no_ack_yet", m0_ack, 0);
    end
    tick(); s_ack = 1'b1; #1;
    check("wr_m0_ack", m0_ack, 1);
    check("wr_m1_ack_err", {m1_ack, m1_err, m0_err}, 0);
    check("wr_s_din_hold", s_din, 16'h8001);
    tick(); s_ack = 1'b0; m0_cyc = 1'b0; #1;
    check("wr_s_cyc_drop", s_cyc, 0);
    check("wr_ack_once", m0_ack, 0);

    // Tie with last = m0 -> m1 wins; m1 reads 0x7FF
    tick();
    m0_cyc = 1'b1; m0_addr = 12'h123; m0_din = 16'h4444; m0_we = 1'b1;
    m1_cyc = 1'b1; m1_addr = 12'h7FF; m1_din = 16'h0000; m1_we = 1'b0;
    #1;
    check("idle_gap", s_cyc, 0);
    tick(); s_ack = 1'b1; s_dout = 16'hBEEF; #1;
    check("rd_s_cyc", s_cyc, 1);
    check("rd_s_addr", s_addr, 12'h7FF);
    check("rd_s_we", s_we, 0);
    check("rd_m1_ack", m1_ack, 1);
    check("rd_m1_dout", m1_dout, 16'hBEEF);
    check("rd_m0_dout", m0_dout, 0);
    check("rd_m0_ack", m0_ack, 0);
    tick(); s_ack = 1'b0; s_dout = 16'h0000; m1_cyc = 1'b0; #1;
    check("rd_s_cyc_drop", s_cyc, 0);
    check("rd_m1_dout_after", m1_dout, 0);

    // m0 granted; fields stable while inputs wiggle; core never acks
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (k == 1) begin
        m1_cyc = 1'b1; m1_addr = 12'h055; m1_din = 16'h1234; m1_we = 1'b1;
      end
      if (k <= 5) begin
        m0_addr = 12'h123 ^ 12'(k);
        m0_din  = 16'h4444 + 16'(k);
      end
      #1;
      check("to_s_cyc", s_cyc, 1);
      check("stab_s_addr", s_addr, 12'h123);
      check("stab_s_din", s_din, 16'h4444);
      check("to_m0_err", m0_err, (k == 128) ? 1 : 0);
      check("to_m0_ack", m0_ack, 0);
      check("to_m1_err", m1_err, 0);
      if (k == 128) check("to_count_pre", to_count, 0);
    end
    tick(); m0_cyc = 1'b0; #1;
    check("to_s_cyc_drop", s_cyc, 0);
    check("to_m0_err_once", m0_err, 0);
    check("to_count_1", to_count, 1);

    // m1 granted next; ack arrives on the timeout cycle -> ack wins
    for (int j = 1; j <= 128; j++) begin
      tick();
      if (j == 128) begin
        s_ack = 1'b1; s_dout = 16'hCAFE;
      end
      #1;
      check("ackto_s_cyc", s_cyc, 1);
      check("ackto_s_addr", s_addr, 12'h055);
      check("ackto_s_din", s_din, 16'h1234);
      check("ackto_m1_ack", m1_ack, (j == 128) ? 1 : 0);
      check("ackto_m1_err", m1_err, 0);
      if (j == 128) begin
        check("ackto_m1_dout", m1_dout, 16'hCAFE);
        check("ackto_m0_ack", m0_ack, 0);
      end
    end
    tick(); s_ack = 1'b0; s_dout = 16'h0000; m1_cyc = 1'b0; #1;
    check("ackto_s_cyc_drop", s_cyc, 0);
    check("ackto_count_same", to_count, 1);
    check("ackto_ack_once", m1_ack, 0);

    // Reset 5 cycles into an m0 transaction (last = m0 before reset)
    m0_cyc = 1'b1; m0_addr = 12'h3AA; m0_din = 16'h5555; m0_we = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(); #1;
      check("rb_s_cyc", s_cyc, 1);
      check("rb_s_addr", s_addr, 12'h3AA);
      check("rb_no_pulse", {m0_ack, m0_err}, 0);
      if (i == 5) rst = 1'b1;
    end
    tick(); #1;
    check("rb_s_cyc_drop", s_cyc, 0);
    check("rb_s_addr_rst", s_addr, 0);
    check("rb_to_count", to_count, 0);
    check("rb_no_pulse_after", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    rst = 1'b0; m0_cyc = 1'b0;
    tick(); #1;
    check("rb_idle", s_cyc, 0);

    // Contention after reset: m0, m1, m0, m1 with one idle cycle between
    m0_cyc = 1'b1; m0_addr = 12'h100; m0_din = 16'h0000; m0_we = 1'b0;
    m1_cyc = 1'b1; m1_addr = 12'h200; m1_din = 16'h0000; m1_we = 1'b0;
    tick(); s_ack = 1'b1; #1;
    check("ct1_addr", s_addr, 12'h100);
    check("ct1_acks", {m0_ack, m1_ack}, 2'b10);
    tick(); s_ack = 1'b0; m0_cyc = 1'b0; #1;
    check("ct1_gap", s_cyc, 0);
    tick(); m0_cyc = 1'b1; s_ack = 1'b1; #1;
    check("ct2_s_cyc", s_cyc, 1);
    check("ct2_addr", s_addr, 12'h200);
    check("ct2_acks", {m0_ack, m1_ack}, 2'b01);
    tick(); s_ack = 1'b0; m1_cyc = 1'b0; #1;
    check("ct2_gap", s_cyc, 0);
    tick(); m1_cyc = 1'b1; s_ack = 1'b1; #1;
    check("ct3_addr", s_addr, 12'h100);
    check("ct3_acks", {m0_ack, m1_ack}, 2'b10);
    tick(); s_ack = 1'b0; m0_cyc = 1'b0; #1;
    check("ct3_gap", s_cyc, 0);
    tick(); s_ack = 1'b1; #1;
    check("ct4_addr", s_addr, 12'h200);
    check("ct4_acks", {m0_ack, m1_ack}, 2'b01);
    tick(); s_ack = 1'b0; m1_cyc = 1'b0; #1;
    check("ct4_gap", s_cyc, 0);

    // s_ack while IDLE is ignored
    tick(); s_ack = 1'b1; s_dout = 16'h1111; #1;
    check("idle_ack_ignored", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check("idle_dout_zero", {m0_dout, m1_dout}, 0);
    tick(); s_ack = 1'b0; #1;
    check("idle_stays", s_cyc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
